id_fetch_queue: RTL

- Parametrised instruction buffer between instruction memory and the decode stage.
- Replaces decode's single-entry stall buffer with a DEPTH-entry response queue.
- Tracks outstanding fetches so responses that were in flight at a flush are discarded.
- Adds an RVC aligner that presents 16-bit and 32-bit instructions, including ones straddling two fetch words, with their PC.

---
 rtl/id_fetch_queue.sv | 133 +++++++++++++
 1 files changed

// File: rtl/id_fetch_queue.sv
// Fetch-response queue between instruction memory and decode, with stale-response
// discard after a redirect and an RVC aligner for 16/32-bit and straddling instructions.
module id_fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 4,
  parameter int RVC_EN  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  input  logic                         i_req,
  output logic                         o_req_ok,
  input  logic                         i_resp,
  input  logic [31:0]                  i_rdata,
  input  logic [31:0]                  i_resp_pc,
  output logic                         o_valid,
  output logic [31:0]                  o_inst,
  output logic                         o_compressed,
  output logic [31:0]                  o_pc,
  output logic [31:0]                  o_pc_next,
  input  logic                         i_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = $clog2(MAX_OUT+1);
  localparam int SW = 8;

  typedef struct packed {
    logic [31:0] word;
    logic [29:0] pc;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [OW-1:0]   r_outst;
  logic [SW-1:0]   r_stale;
  logic            r_hoff, r_first, r_overflow;

  entry_t          w_head, w_next;
  logic [15:0]     w_half;
  logic            w_is_comp, w_straddle, w_avail, w_valid, w_fire, w_pop;
  logic            w_accept, w_full, w_push, w_drop, w_outst_dec;
  logic [SW-1:0]   w_inflight, w_stale_flush;
  logic            w_unused;

  assign w_head     = r_mem[r_rd_ptr];
  assign w_next     = r_mem[r_rd_ptr + AW'(1)];
  assign w_half     = r_hoff ? w_head.word[31:16] : w_head.word[15:0];
  assign w_is_comp  = (RVC_EN != 0) && (w_half[1:0] != 2'b11);
  // A 32-bit instruction starting in the upper half needs the next word present too.
  assign w_straddle = r_hoff && !w_is_comp;
  assign w_avail    = w_straddle ? (r_count >= CW'(2)) : (r_count != '0);
  assign w_valid    = w_avail && !i_flush;
  assign w_fire     = w_valid && i_ready;
  assign w_pop      = w_fire && (!w_is_comp || r_hoff);

  assign w_accept    = i_resp && (r_stale == '0) && !i_flush;
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_drop      = w_accept && w_full && !w_pop;
  assign w_push      = w_accept && !w_drop;
  assign w_outst_dec = w_accept && (r_outst != '0);

  // Everything still in flight at a redirect becomes stale; the same-cycle response retires one.
  assign w_inflight    = r_stale + SW'(r_outst) + SW'(i_req);
  assign w_stale_flush = (i_resp && (w_inflight != '0)) ? w_inflight - SW'(1) : w_inflight;

  assign w_unused = ^{i_resp_pc[0], w_next.word[31:16], w_next.pc};

  always_comb begin
    o_valid      = w_valid;
    o_inst       = '0;
    o_compressed = 1'b0;
    o_pc         = '0;
    o_pc_next    = '0;
    if (w_valid) begin
      o_compressed = w_is_comp;
      o_pc         = {w_head.pc, r_hoff, 1'b0};
      o_pc_next    = o_pc + (w_is_comp ? 32'd2 : 32'd4);
      if (w_is_comp)       o_inst = {16'h0, w_half};
      else if (w_straddle) o_inst = {w_next.word[15:0], w_half};
      else                 o_inst = w_head.word;
    end
  end

  assign o_req_ok   = ((32'(r_count) + 32'(r_outst)) < 32'(DEPTH)) && (32'(r_outst) < 32'(MAX_OUT));
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

  // NOTE: the storage array has no reset; r_count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= {i_rdata, i_resp_pc[31:2]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_outst    <= '0;
      r_stale    <= '0;
      r_hoff     <= 1'b0;
      r_first    <= 1'b1;
      r_overflow <= 1'b0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_outst  <= '0;
      r_stale  <= w_stale_flush;
      r_hoff   <= 1'b0;
      r_first  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_outst <= r_outst + OW'(i_req) - OW'(w_outst_dec);
      if (i_resp && (r_stale != '0)) r_stale <= r_stale - SW'(1);
      if (w_drop) r_overflow <= 1'b1;
      // The first word after a redirect may start mid-word; later alignment follows consumption.
      if (w_push && r_first) begin
        r_first <= 1'b0;
        r_hoff  <= (RVC_EN != 0) && i_resp_pc[1];
      end else if (w_fire && w_is_comp) begin
        r_hoff <= !r_hoff;
      end
    end
  end

endmodule
